// File: rtl/timer_ctrl_pkg.sv
// Shared types and default constants for the MM:SS countdown sequencer.
// Imported by timer_ctrl and its button auto-repeat helper.
package timer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALARM = 2'd2
    } state_e;

    typedef struct packed {
        logic inc_sec;
        logic inc_min;
        logic dec_sec;
        logic clr;
    } strobe_t;

    localparam int unsigned DEF_REPEAT_DELAY = 50_000_000;
    localparam int unsigned DEF_REPEAT_RATE  = 12_500_000;
    localparam int unsigned DEF_ALARM_SECS   = 10;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/timer_ctrl_btn_repeat.sv
// btn_repeat: rising-edge detect plus auto-repeat for one ADD button.
// fire_o requests a strobe on the edge and on each repeat interval while held.
module timer_ctrl_btn_repeat
    import timer_ctrl_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic cancel_i,
    input  logic btn_i,
    output logic edge_o,
    output logic fire_o
);

    localparam int unsigned CW = $clog2(max_u(REPEAT_DELAY, REPEAT_RATE) + 1);

    logic          prev_q;
    logic          armed_q, armed_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign edge_o = btn_i & ~prev_q;

    // The counter reloads with interval-1 so that it reaches zero exactly on the repeat cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        armed_d = armed_q;
        cnt_d   = cnt_q;
        fire_o  = 1'b0;
        if (!en_i || cancel_i || !btn_i) begin
            armed_d = 1'b0;
            cnt_d   = '0;
        end else if (edge_o) begin
            fire_o  = 1'b1;
            armed_d = 1'b1;
            cnt_d   = CW'(REPEAT_DELAY - 1);
        end else if (armed_q) begin
            if (cnt_q == '0) begin
                fire_o = 1'b1;
                cnt_d  = CW'(REPEAT_RATE - 1);
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            prev_q  <= btn_i;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Sequencer for the MM:SS countdown chain: turns button levels and the 1 Hz tick
// into single-cycle counter strobes and tracks the SET/RUN/ALARM mode.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter int unsigned ALARM_SECS   = DEF_ALARM_SECS
) (
    input  logic mclk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic bt_start_i,
    input  logic bt_reset_i,
    input  logic bt_sec_i,
    input  logic bt_min_i,
    input  logic zero_i,
    output logic inc_sec_o,
    output logic inc_min_o,
    output logic dec_sec_o,
    output logic clr_o,
    output logic running_o,
    output logic alarm_o,
    output logic blank_o
);

    localparam int unsigned TW = $clog2(ALARM_SECS + 1);

    state_e        state_q, state_d;
    strobe_t       strobe_q, strobe_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          blank_q, blank_d;
    logic          start_prev_q, reset_prev_q;
    logic          start_edge, reset_edge;
    logic          sec_edge, sec_fire, min_edge, min_fire;
    logic          rep_en;

    assign start_edge = bt_start_i & ~start_prev_q;
    assign reset_edge = bt_reset_i & ~reset_prev_q;
    assign rep_en     = (state_q == ST_SET);

    // A higher-priority action kills any lower-priority repeat in progress.
    timer_ctrl_btn_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_min_rep (
        .clk_i    (mclk_i),
        .rst_i    (rst_i),
        .en_i     (rep_en),
        .cancel_i (start_edge | reset_edge),
        .btn_i    (bt_min_i),
        .edge_o   (min_edge),
        .fire_o   (min_fire)
    );

    timer_ctrl_btn_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_sec_rep (
        .clk_i    (mclk_i),
        .rst_i    (rst_i),
        .en_i     (rep_en),
        .cancel_i (start_edge | reset_edge | min_fire),
        .btn_i    (bt_sec_i),
        .edge_o   (sec_edge),
        .fire_o   (sec_fire)
    );

    always_comb begin
        state_d    = state_q;
        strobe_d   = '0;
        tick_cnt_d = tick_cnt_q;
        blank_d    = blank_q;
        case (state_q)
            ST_SET: begin
                tick_cnt_d = '0;
                blank_d    = 1'b0;
                if (start_edge) begin
                    if (!zero_i) state_d = ST_RUN;
                end else if (reset_edge) begin
                    strobe_d.clr = 1'b1;
                end else if (min_fire) begin
                    strobe_d.inc_min = 1'b1;
                end else if (sec_fire) begin
                    strobe_d.inc_sec = 1'b1;
                end
            end
            ST_RUN: begin
                if (start_edge) begin
                    state_d = ST_SET;
                end else if (zero_i) begin
                    state_d    = ST_ALARM;
                    tick_cnt_d = '0;
                    blank_d    = 1'b0;
                end else if (tick_i) begin
                    strobe_d.dec_sec = 1'b1;
                end
            end
            ST_ALARM: begin
                // The exit fires the cycle after the last counted tick, so that tick's blink phase is shown.
                if (start_edge || reset_edge || sec_edge || min_edge ||
                    tick_cnt_q == TW'(ALARM_SECS)) begin
                    state_d    = ST_SET;
                    tick_cnt_d = '0;
                    blank_d    = 1'b0;
                end else if (tick_i) begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                    blank_d    = ~blank_q;
                end
            end
            default: begin
                state_d = ST_SET;
            end
        endcase
    end

    always_ff @(posedge mclk_i) begin
        if (rst_i) begin
            state_q      <= ST_SET;
            strobe_q     <= '0;
            tick_cnt_q   <= '0;
            blank_q      <= 1'b0;
            start_prev_q <= 1'b1;
            reset_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            strobe_q     <= strobe_d;
            tick_cnt_q   <= tick_cnt_d;
            blank_q      <= blank_d;
            start_prev_q <= bt_start_i;
            reset_prev_q <= bt_reset_i;
        end
    end

    assign inc_sec_o = strobe_q.inc_sec;
    assign inc_min_o = strobe_q.inc_min;
    assign dec_sec_o = strobe_q.dec_sec;
    assign clr_o     = strobe_q.clr;
    assign running_o = (state_q == ST_RUN);
    assign alarm_o   = (state_q == ST_ALARM);
    assign blank_o   = blank_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios plus random stimulus, every cycle compared
// against a behavioural model that also emulates the seconds counter chain.
module tb_timer_ctrl;

    localparam int D = 8;
    localparam int R = 4;
    localparam int A = 3;
    localparam int M_SET = 0, M_RUN = 1, M_ALARM = 2;

    logic mclk = 1'b0;
    logic rst = 1'b1, tick = 1'b0, zero = 1'b1;
    logic bt_start = 1'b0, bt_reset = 1'b0, bt_sec = 1'b0, bt_min = 1'b0;
    logic inc_sec, inc_min, dec_sec, clr, running, alarm, blank;

    int n_checks = 0, n_errors = 0;
    int cyc = 0;
    int n_inc_sec = 0, n_inc_min = 0, n_dec = 0, n_clr = 0;
    int sec_q[$];

    // model state
    int   m_mode = M_SET;
    bit   p_start = 1, p_reset = 1, p_sec = 1, p_min = 1;
    int   sec_hold = -1, min_hold = -1, m_ticks = 0;
    bit   m_blank = 0;
    int   cnt_m = 0;
    logic [6:0] exp_cur = '0, exp_nxt = '0;

    timer_ctrl #(
        .REPEAT_DELAY (D),
        .REPEAT_RATE  (R),
        .ALARM_SECS   (A)
    ) dut (
        .mclk_i     (mclk),
        .rst_i      (rst),
        .tick_i     (tick),
        .bt_start_i (bt_start),
        .bt_reset_i (bt_reset),
        .bt_sec_i   (bt_sec),
        .bt_min_i   (bt_min),
        .zero_i     (zero),
        .inc_sec_o  (inc_sec),
        .inc_min_o  (inc_min),
        .dec_sec_o  (dec_sec),
        .clr_o      (clr),
        .running_o  (running),
        .alarm_o    (alarm),
        .blank_o    (blank)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Held for hold+1 cycles since the first strobe: repeats at D, D+R, D+2R, ...
    function automatic bit rep_due(input int hold);
        int n;
        if (hold < 0) return 1'b0;
        n = hold + 1;
        return (n == D) || (n > D && ((n - D) % R) == 0);
    endfunction

    task automatic model_eval();
        bit es, er, esc, emn, sfire, mfire;
        bit is = 0, im = 0, id = 0, ic = 0;
        if (rst) begin
            m_mode = M_SET; p_start = 1; p_reset = 1; p_sec = 1; p_min = 1;
            sec_hold = -1; min_hold = -1; m_ticks = 0; m_blank = 0;
            exp_nxt = '0;
            return;
        end
        es  = bt_start && !p_start;
        er  = bt_reset && !p_reset;
        esc = bt_sec   && !p_sec;
        emn = bt_min   && !p_min;
        case (m_mode)
            M_SET: begin
                m_ticks = 0; m_blank = 0;
                if (!bt_sec) sec_hold = -1;
                if (!bt_min) min_hold = -1;
                sfire = esc || rep_due(sec_hold);
                mfire = emn || rep_due(min_hold);
                if (es) begin
                    if (!zero) m_mode = M_RUN;
                    sec_hold = -1; min_hold = -1;
                end else if (er) begin
                    ic = 1; sec_hold = -1; min_hold = -1;
                end else if (mfire) begin
                    im = 1; min_hold = emn ? 0 : min_hold + 1; sec_hold = -1;
                end else begin
                    if (min_hold >= 0) min_hold++;
                    if (sfire) begin
                        is = 1; sec_hold = esc ? 0 : sec_hold + 1;
                    end else if (sec_hold >= 0) begin
                        sec_hold++;
                    end
                end
            end
            M_RUN: begin
                sec_hold = -1; min_hold = -1;
                if (es) m_mode = M_SET;
                else if (zero) begin m_mode = M_ALARM; m_ticks = 0; m_blank = 0; end
                else if (tick) id = 1;
            end
            default: begin
                sec_hold = -1; min_hold = -1;
                if (es || er || esc || emn || m_ticks == A) begin
                    m_mode = M_SET; m_ticks = 0; m_blank = 0;
                end else if (tick) begin
                    m_ticks++;
                    m_blank = (m_ticks % 2) == 1;
                end
            end
        endcase
        p_start = bt_start; p_reset = bt_reset; p_sec = bt_sec; p_min = bt_min;
        exp_nxt = {is, im, id, ic, m_mode == M_RUN, m_mode == M_ALARM, m_blank};
    endtask

    task automatic step();
        model_eval();
        @(posedge mclk);
        // The counter chain acts on the strobes that were visible during the previous cycle.
        if (exp_cur[6]) cnt_m = (cnt_m + 1) % 3600;
        if (exp_cur[5]) cnt_m = (cnt_m + 60) % 3600;
        if (exp_cur[4] && cnt_m > 0) cnt_m = cnt_m - 1;
        if (exp_cur[3]) cnt_m = 0;
        exp_cur = exp_nxt;
        #1;
        cyc++;
        check("outs", {inc_sec, inc_min, dec_sec, clr, running, alarm, blank}, exp_cur);
        if (inc_sec) begin n_inc_sec++; sec_q.push_back(cyc); end
        if (inc_min) n_inc_min++;
        if (dec_sec) n_dec++;
        if (clr) n_clr++;
        zero = (cnt_m == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press_start(); bt_start = 1; step(); bt_start = 0; step(); endtask
    task automatic press_reset(); bt_reset = 1; step(); bt_reset = 0; step(); endtask
    task automatic press_sec();   bt_sec   = 1; step(); bt_sec   = 0; step(); endtask
    task automatic press_min();   bt_min   = 1; step(); bt_min   = 0; step(); endtask
    task automatic do_tick();     tick     = 1; step(); tick     = 0; endtask

    initial begin
        int exp_off[4] = '{0, 8, 12, 16};
        int exp_blank[3] = '{1, 0, 1};
        int base, off;

        run(2);
        check("reset_outs", {inc_sec, inc_min, dec_sec, clr, running, alarm, blank}, 7'd0);
        rst = 0;
        run(2);

        // 1: held ADD-second button auto-repeats
        sec_q.delete();
        bt_sec = 1; run(18); bt_sec = 0; run(3);
        check("t1_count", sec_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            off = (i < sec_q.size()) ? sec_q[i] - sec_q[0] : -1;
            check($sformatf("t1_off%0d", i), off, exp_off[i]);
        end

        // 2: count down 00:03 into alarm
        press_reset();
        press_sec(); press_sec(); press_sec();
        check("t2_preset", cnt_m, 3);
        press_start(); run(2);
        check("t2_running", running, 1);
        base = n_dec;
        for (int i = 0; i < 3; i++) begin do_tick(); run(3); end
        check("t2_dec_count", n_dec - base, 3);
        check("t2_alarm", alarm, 1);
        check("t2_not_running", running, 0);

        // 3: alarm blink and timeout, then a RESET press leaves alarm without CLR
        for (int i = 0; i < 3; i++) begin
            run(2); do_tick();
            check($sformatf("t3_blank%0d", i), blank, exp_blank[i]);
        end
        step();
        check("t3_exit_alarm", alarm, 0);
        check("t3_exit_blank", blank, 0);
        press_sec(); press_sec();
        press_start(); run(2);
        do_tick(); run(2); do_tick(); run(4);
        check("t3_alarm_again", alarm, 1);
        base = n_clr;
        press_reset();
        check("t3_reset_exit", alarm, 0);
        check("t3_no_clr", n_clr - base, 0);

        // 4: START beats RESET; RUN ignores RESET/MIN
        press_reset(); press_min();
        check("t4_preset", cnt_m, 60);
        base = n_clr;
        bt_start = 1; bt_reset = 1; step(); bt_start = 0; bt_reset = 0; step();
        check("t4_running", running, 1);
        check("t4_no_clr", n_clr - base, 0);
        base = n_inc_min + n_clr + n_inc_sec;
        press_min(); press_reset();
        bt_min = 1; run(20); bt_min = 0; step();
        check("t4_run_ignores", n_inc_min + n_clr + n_inc_sec - base, 0);
        press_start();
        check("t4_paused", running, 0);

        // 5: START at zero is ignored; START held through reset makes no edge
        press_reset(); press_start();
        check("t5_zero_start", running, 0);
        press_sec();
        bt_start = 1; rst = 1; run(2); rst = 0; run(3);
        check("t5_held_rst", running, 0);
        bt_start = 0; step();

        // 6: reset coinciding with a TICK in RUN
        press_start();
        check("t6_running", running, 1);
        base = n_dec;
        tick = 1; rst = 1; step(); tick = 0; rst = 0;
        check("t6_rst_outs", {inc_sec, inc_min, dec_sec, clr, running, alarm, blank}, 7'd0);
        check("t6_no_dec", n_dec - base, 0);
        run(2);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) bt_sec   = ~bt_sec;
            if ($urandom_range(15) == 0) bt_min   = ~bt_min;
            if ($urandom_range(23) == 0) bt_start = ~bt_start;
            if ($urandom_range(23) == 0) bt_reset = ~bt_reset;
            tick = ($urandom_range(7) == 0);
            rst  = ($urandom_range(499) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
